lock_chamber_controller: RTL and testbench
==========================================

LOCK_CHAMBER_CONTROLLER -- requirements
Module: lock_chamber_controller

Interface
REQ-001 SHALL have parameter OUTSIDE_LEVEL, default 14'd100: outside water level; the lock must match it before the outer gate opens.
REQ-002 SHALL have parameter INNER_LEVEL, default 14'd1100: inner water level; the lock must match it before the inner gate opens.
REQ-003 SHALL have parameter STEP, default 14'd10: largest change in lock level per tick.
REQ-004 SHALL have parameter DWELL, default 5: number of ticks a gate stays open.
REQ-005 SHALL use one clock with synchronous, active-high reset: `clk  in  1  system clock`.
REQ-006 SHALL have `reset  in  1  synchronous active-high reset`.
REQ-007 SHALL have `tick  in  1  one-cycle time-base enable; level and dwell advance only when tick=1`.
REQ-008 SHALL have `req_out  in  1  boat waiting outside (pulse or level)`.
REQ-009 SHALL have `req_in  in  1  boat waiting inner side (pulse or level)`.
REQ-010 SHALL have `lock_level  out  14  current lock water level (feeds the lock display)`.
REQ-011 SHALL have `outer_open  out  1  outer gate open`.
REQ-012 SHALL have `inner_open  out  1  inner gate open`.
REQ-013 SHALL have `busy  out  1  transit in progress`.
REQ-014 SHALL have `done  out  1  one-cycle pulse when a transit completes`.

Function
REQ-015 SHALL implement states IDLE, EQ_OUT, OPEN_OUT, EQ_IN, OPEN_IN, plus a direction bit dir (0 = outside->inner, 1 = inner->outside).
REQ-016 SHALL latch each request into pend_out/pend_in on any cycle its input is 1, including while busy.
REQ-017 SHALL clear a pending flag on the cycle its transit leaves IDLE.
REQ-018 SHALL, in IDLE with pend_out only: set dir=0 and go to EQ_OUT; with pend_in only: set dir=1 and go to EQ_IN.
REQ-019 SHALL, in IDLE with both pending: serve the side whose level already equals lock_level; if neither matches, serve outside. The other flag stays pending.
REQ-020 SHALL exit IDLE one cycle after the pending flag is seen; this does not wait for tick.
REQ-021 SHALL, in EQ_x on a tick, set diff = target − lock_level, where target is OUTSIDE_LEVEL or INNER_LEVEL for that side.
REQ-022 SHALL set lock_level to target if |diff| ≤ STEP, else move it by ±STEP toward target.
REQ-023 SHALL never let lock_level overshoot target and never wrap. Arithmetic SHALL use a 15-bit signed difference.
REQ-024 SHALL move EQ_x -> OPEN_x on the cycle after lock_level == target. If the level already matches on entry, the move SHALL happen on the next cycle with no tick consumed.
REQ-025 SHALL hold outer_open = 1 only in OPEN_OUT and inner_open = 1 only in OPEN_IN. The two SHALL never both be 1.
REQ-026 SHALL hold lock_level constant while either gate is open.
REQ-027 SHALL, in OPEN_x, count ticks from 0 and leave after DWELL ticks.
REQ-028 SHALL, on leaving the entry-side OPEN state (OPEN_OUT when dir=0, OPEN_IN when dir=1), go to the opposite EQ state.
REQ-029 SHALL, on leaving the exit-side OPEN state, return to IDLE and pulse done for exactly one cycle.
REQ-030 SHALL drive busy = 1 in every state except IDLE.
REQ-031 SHALL ignore tick in IDLE.
REQ-032 SHALL register all outputs (no combinational input->output paths).

Reset
REQ-033 SHALL, on reset=1 at a clock edge: state=IDLE, lock_level=OUTSIDE_LEVEL, outer_open=0, inner_open=0, busy=0, done=0, pend_out=0, pend_in=0, dwell counter=0, dir=0.
REQ-034 SHALL give reset priority over tick and requests, including mid-transit.
REQ-035 SHALL close any open gate and snap the level to OUTSIDE_LEVEL on the cycle after reset is sampled.

Verification
REQ-036 SHALL cover: reset, then req_out pulse -> outer_open for 5 ticks; lock_level rises 100->1100 in 100 ticks; inner_open for 5 ticks; then done pulse, busy=0.
REQ-037 SHALL cover: after that transit (level 1100), req_in -> inner_open immediately for 5 ticks; level falls to 100 in 100 ticks; outer_open 5 ticks; done.
REQ-038 SHALL cover: STEP=300 with OUTSIDE_LEVEL=100 and INNER_LEVEL=1100 -> levels 400, 700, 1000, then 1100 exactly (no overshoot).
REQ-039 SHALL cover: req_out and req_in in the same cycle at level 100 -> outside served first; inner transit starts right after done, with no new request needed.
REQ-040 SHALL cover: reset asserted mid-EQ_IN at level 550 -> next cycle lock_level=100, both gates 0, busy=0, pending flags cleared.
REQ-041 SHALL cover: tick held 0 during EQ_IN -> lock_level frozen, gates closed, busy=1; a monitor asserts outer_open & inner_open is never 1 in any test.

Source files
------------

// File: rtl/lock_chamber_controller.sv
// Canal lock chamber sequencer: equalises the chamber level toward the side being
// served, opens that gate for a fixed number of ticks, then carries the boat across.
module lock_chamber_controller #(
    parameter logic [13:0] OUTSIDE_LEVEL = 14'd100,
    parameter logic [13:0] INNER_LEVEL   = 14'd1100,
    parameter logic [13:0] STEP          = 14'd10,
    parameter int          DWELL         = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        req_out,
    input  logic        req_in,
    output logic [13:0] lock_level,
    output logic        outer_open,
    output logic        inner_open,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        EQ_OUT,
        OPEN_OUT,
        EQ_IN,
        OPEN_IN
    } state_t;

    localparam logic [15:0]        DWELL_LAST = 16'(DWELL - 1);
    localparam logic signed [14:0] STEP_S     = {1'b0, STEP};

    state_t              state;
    state_t              state_next;
    logic                dir;
    logic                dir_next;
    logic                pend_out;
    logic                pend_in;
    logic                clr_out;
    logic                clr_in;
    logic                serve_in;
    logic                entry_side;
    logic                done_next;
    logic [13:0]         level_next;
    logic [13:0]         target;
    logic signed [14:0]  diff;
    logic [15:0]         dwell_cnt;
    logic [15:0]         dwell_next;

    // With both sides waiting, the inner boat only goes first when the chamber already sits at its level.
    assign serve_in = pend_in &&
                      (!pend_out || (lock_level == INNER_LEVEL && lock_level != OUTSIDE_LEVEL));

    assign target     = (state == EQ_IN) ? INNER_LEVEL : OUTSIDE_LEVEL;
    assign diff       = $signed({1'b0, target}) - $signed({1'b0, lock_level});
    assign entry_side = (state == OPEN_OUT && !dir) || (state == OPEN_IN && dir);

    always_comb begin
        state_next = state;
        dir_next   = dir;
        level_next = lock_level;
        dwell_next = dwell_cnt;
        done_next  = 1'b0;
        clr_out    = 1'b0;
        clr_in     = 1'b0;

        case (state)
            IDLE: begin
                if (pend_out || pend_in) begin
                    if (serve_in) begin
                        dir_next   = 1'b1;
                        state_next = EQ_IN;
                        clr_in     = 1'b1;
                    end else begin
                        dir_next   = 1'b0;
                        state_next = EQ_OUT;
                        clr_out    = 1'b1;
                    end
                end
            end

            EQ_OUT, EQ_IN: begin
                if (lock_level == target) begin
                    state_next = (state == EQ_OUT) ? OPEN_OUT : OPEN_IN;
                    dwell_next = 16'd0;
                end else if (tick) begin
                    // Stepping only happens while more than STEP away, so the level can never overshoot or wrap.
                    if (diff > STEP_S) begin
                        level_next = lock_level + STEP;
                    end else if (diff < -STEP_S) begin
                        level_next = lock_level - STEP;
                    end else begin
                        level_next = target;
                    end
                end
            end

            OPEN_OUT, OPEN_IN: begin
                if (tick) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_next = 16'd0;
                        if (entry_side) begin
                            state_next = (state == OPEN_OUT) ? EQ_IN : EQ_OUT;
                        end else begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        dwell_next = dwell_cnt + 16'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dir        <= 1'b0;
            lock_level <= OUTSIDE_LEVEL;
            dwell_cnt  <= 16'd0;
            pend_out   <= 1'b0;
            pend_in    <= 1'b0;
            outer_open <= 1'b0;
            inner_open <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            dir        <= dir_next;
            lock_level <= level_next;
            dwell_cnt  <= dwell_next;
            pend_out   <= (pend_out & ~clr_out) | req_out;
            pend_in    <= (pend_in & ~clr_in) | req_in;
            outer_open <= (state_next == OPEN_OUT);
            inner_open <= (state_next == OPEN_IN);
            busy       <= (state_next != IDLE);
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_lock_chamber_controller.sv
// Directed bench for lock_chamber_controller: a default-parameter instance for the
// transit/reset scenarios and a STEP=300 instance for the no-overshoot case.
module tb_lock_chamber_controller;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        req_out;
    logic        req_in;
    logic [13:0] lock_level;
    logic        outer_open;
    logic        inner_open;
    logic        busy;
    logic        done;

    logic        tick_b;
    logic        req_out_b;
    logic        req_in_b;
    logic [13:0] level_b;
    logic        outer_b;
    logic        inner_b;
    logic        busy_b;
    logic        done_b;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic        tk;
        logic        ro;
        logic        ri;
        logic [13:0] lvl;
        logic        o;
        logic        i;
        logic        b;
        logic        d;
    } vec_t;

    vec_t vecs[13];

    lock_chamber_controller dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .req_out    (req_out),
        .req_in     (req_in),
        .lock_level (lock_level),
        .outer_open (outer_open),
        .inner_open (inner_open),
        .busy       (busy),
        .done       (done)
    );

    lock_chamber_controller #(
        .OUTSIDE_LEVEL (14'd100),
        .INNER_LEVEL   (14'd1100),
        .STEP          (14'd300),
        .DWELL         (5)
    ) dut_big (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_b),
        .req_out    (req_out_b),
        .req_in     (req_in_b),
        .lock_level (level_b),
        .outer_open (outer_b),
        .inner_open (inner_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both gates open at once is never legal, whatever test is running.
    always @(negedge clk) begin
        if (outer_open === 1'b1 && inner_open === 1'b1) begin
            mismatched++;
            $display("[TB] FAIL gate_interlock: outer_open=1 inner_open=1, required not both 1");
        end
        if (outer_b === 1'b1 && inner_b === 1'b1) begin
            mismatched++;
            $display("[TB] FAIL gate_interlock_big: outer_open=1 inner_open=1, required not both 1");
        end
    end

    task automatic compare(input string name, input logic [17:0] got, input logic [17:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got level=%0d outer=%b inner=%b busy=%b done=%b, required level=%0d outer=%b inner=%b busy=%b done=%b",
                     name, got[17:4], got[3], got[2], got[1], got[0],
                     exp[17:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic t, input logic ro, input logic ri);
        reset   = r;
        tick    = t;
        req_out = ro;
        req_in  = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_big(input logic t, input logic ro);
        tick_b    = t;
        req_out_b = ro;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [13:0] lvl, input logic o,
                                input logic i, input logic b, input logic d);
        compare(name, {lock_level, outer_open, inner_open, busy, done}, {lvl, o, i, b, d});
    endtask

    task automatic check_big(input string name, input logic [13:0] lvl, input logic o,
                             input logic i, input logic b, input logic d);
        compare(name, {level_b, outer_b, inner_b, busy_b, done_b}, {lvl, o, i, b, d});
    endtask

    // Ticks the chamber from start to goal in steps of 10, checking every intermediate level.
    task automatic equalize(input string name, input logic [13:0] start, input logic [13:0] goal);
        logic [13:0] exp;
        int          n;
        exp = start;
        n   = 0;
        while (exp != goal && n < 2000) begin
            if (goal > exp) exp = (goal - exp <= 14'd10) ? goal : exp + 14'd10;
            else            exp = (exp - goal <= 14'd10) ? goal : exp - 14'd10;
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
            check_output(name, exp, 1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
    endtask

    // Five dwell ticks on an open gate; the last one either crosses over or finishes the transit.
    task automatic dwell(input string name, input logic outer_side, input logic last, input logic [13:0] lvl);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
            check_output(name, lvl, outer_side, !outer_side, 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        if (last) check_output({name, "_end"}, lvl, 1'b0, 1'b0, 1'b0, 1'b1);
        else      check_output({name, "_end"}, lvl, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        tick       = 1'b0;
        req_out    = 1'b0;
        req_in     = 1'b0;
        tick_b     = 1'b0;
        req_out_b  = 1'b0;
        req_in_b   = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 14'd100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd100, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd100, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd110, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd110, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd120, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset, outer request, outer dwell and the first inward steps.
        for (int k = 0; k < 13; k++) begin
            apply_stimulus(vecs[k].rst, vecs[k].tk, vecs[k].ro, vecs[k].ri);
            check_output($sformatf("vec%0d", k), vecs[k].lvl, vecs[k].o, vecs[k].i, vecs[k].b, vecs[k].d);
        end

        // Finish the outside->inner transit.
        equalize("rise", 14'd120, 14'd1100);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("open_in", 14'd1100, 1'b0, 1'b1, 1'b1, 1'b0);
        dwell("dwell_in", 1'b0, 1'b1, 14'd1100);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("done_one_cycle", 14'd1100, 1'b0, 1'b0, 1'b0, 1'b0);

        // Inner->outside transit from a matching level.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("req_in_latch", 14'd1100, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("eq_in_enter", 14'd1100, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("open_in_now", 14'd1100, 1'b0, 1'b1, 1'b1, 1'b0);
        dwell("dwell_in2", 1'b0, 1'b0, 14'd1100);
        equalize("fall", 14'd1100, 14'd100);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("open_out2", 14'd100, 1'b1, 1'b0, 1'b1, 1'b0);
        dwell("dwell_out2", 1'b1, 1'b1, 14'd100);

        // Simultaneous requests: outside first, inner follows without a new request.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        check_output("both_latch", 14'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("both_eq", 14'd100, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("both_outer_first", 14'd100, 1'b1, 1'b0, 1'b1, 1'b0);
        dwell("both_dwell_out", 1'b1, 1'b0, 14'd100);
        equalize("both_rise", 14'd100, 14'd1100);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("both_open_in", 14'd1100, 1'b0, 1'b1, 1'b1, 1'b0);
        dwell("both_dwell_in", 1'b0, 1'b1, 14'd1100);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("pending_in_start", 14'd1100, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("pending_in_open", 14'd1100, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset mid-EQ_IN at 550, with a request latched while busy and tick frozen.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("reset2", 14'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("r_open_out", 14'd100, 1'b1, 1'b0, 1'b1, 1'b0);
        dwell("r_dwell_out", 1'b1, 1'b0, 14'd100);
        equalize("r_rise", 14'd100, 14'd550);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("req_while_busy", 14'd550, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_output("tick_frozen", 14'd550, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_output("reset_mid_eq", 14'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
            check_output("pend_cleared", 14'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Large STEP instance: 400, 700, 1000 then exactly 1100.
        apply_big(1'b0, 1'b1);
        check_big("big_latch", 14'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_big(1'b0, 1'b0);
        apply_big(1'b0, 1'b0);
        check_big("big_open_out", 14'd100, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) apply_big(1'b1, 1'b0);
        check_big("big_eq_in", 14'd100, 1'b0, 1'b0, 1'b1, 1'b0);
        begin
            logic [13:0] big_exp[4];
            big_exp[0] = 14'd400;
            big_exp[1] = 14'd700;
            big_exp[2] = 14'd1000;
            big_exp[3] = 14'd1100;
            for (int k = 0; k < 4; k++) begin
                apply_big(1'b1, 1'b0);
                check_big($sformatf("big_step%0d", k), big_exp[k], 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
        apply_big(1'b1, 1'b0);
        check_big("big_open_in", 14'd1100, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
